// File: rtl/regfile_onehot_wr.sv
// 16-entry register file with one-hot write select, two registered read ports.
// Optional RF_BYPASS_EN forwards a same-cycle legal write to matching reads.
module regfile_onehot_wr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             sel_err,
  input  logic             err_clr,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] rf_q [16];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             rd_vld_q;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             onehot;
  logic             wr_ok;
  logic             wr_bad;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign onehot = (wr_sel != 16'd0) &&
                  ((wr_sel & (wr_sel - 16'd1)) == 16'd0);
  assign wr_ok  = wr_valid && onehot;
  assign wr_bad = wr_valid && !onehot;

  always_comb begin
    rd_a_d = rf_q[rd_addr_a];
    rd_b_d = rf_q[rd_addr_b];
`ifdef RF_BYPASS_EN
    if (wr_ok && wr_sel[rd_addr_a]) rd_a_d = wr_data;
    if (wr_ok && wr_sel[rd_addr_b]) rd_b_d = wr_data;
`endif
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (wr_bad)  err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < 16; i++)
        if (wr_sel[i]) rf_q[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      rd_vld_q <= rd_en;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      if (rd_en) begin
        rd_a_q <= rd_a_d;
        rd_b_q <= rd_b_d;
      end
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign rd_valid  = rd_vld_q;
  assign sel_err   = err_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr; expectations follow RF_BYPASS_EN.
module tb_regfile_onehot_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_sel;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        rd_en;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid;
  logic        sel_err;
  logic        err_clr;
  logic [7:0]  wr_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_onehot_wr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .sel_err   (sel_err),
    .err_clr   (err_clr),
    .wr_count  (wr_count)
  );

  task automatic idle();
    wr_sel    = 16'h0;
    wr_data   = 8'h0;
    wr_valid  = 1'b0;
    rd_en     = 1'b0;
    rd_addr_a = 4'h0;
    rd_addr_b = 4'h0;
    err_clr   = 1'b0;
  endtask

  // Drive one cycle of stimulus at negedge, return #1 after the rising edge.
  task automatic cyc(input logic [15:0] sel, input logic [7:0] d,
                     input logic wv, input logic re,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic clr);
    @(negedge clk);
    wr_sel = sel; wr_data = d; wr_valid = wv;
    rd_en = re; rd_addr_a = a; rd_addr_b = b; err_clr = clr;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({rd_data_a, rd_data_b, rd_valid, sel_err, wr_count} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outs got a=%h b=%h v=%b e=%b c=%h want 0",
               rd_data_a, rd_data_b, rd_valid, sel_err, wr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd3, 4'd15, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      n_err++;
      $display("FAIL reset_read got a=%h b=%h want 00 00",
               rd_data_a, rd_data_b);
    end
    n_cmp++;
    if (rd_valid !== 1'b1 || sel_err !== 1'b0 || wr_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_flags got v=%b e=%b c=%0d want 1 0 0",
               rd_valid, sel_err, wr_count);
    end
  endtask

  task automatic test_write_read();
    cyc(16'h0020, 8'hA5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    n_cmp++;
    if (wr_count !== 8'd1) begin
      n_err++;
      $display("FAIL wr_count1 got %0d want 1", wr_count);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'hA5 || rd_data_b !== 8'hA5 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL read5 got a=%h b=%h v=%b want a5 a5 1",
               rd_data_a, rd_data_b, rd_valid);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'hA5 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_hold got a=%h v=%b want a5 0", rd_data_a, rd_valid);
    end
  endtask

  task automatic test_illegal();
    cyc(16'h0001, 8'h11, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(16'h0010, 8'h44, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(16'hFFFF, 8'hEE, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    n_cmp++;
    if (sel_err !== 1'b0 || wr_count !== 8'd3) begin
      n_err++;
      $display("FAIL no_valid got e=%b c=%0d want 0 3", sel_err, wr_count);
    end
    cyc(16'h0000, 8'hFF, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    n_cmp++;
    if (sel_err !== 1'b1 || wr_count !== 8'd3) begin
      n_err++;
      $display("FAIL ill_zero got e=%b c=%0d want 1 3", sel_err, wr_count);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr got %b want 0", sel_err);
    end
    cyc(16'h0011, 8'hFF, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    n_cmp++;
    if (sel_err !== 1'b1 || wr_count !== 8'd3) begin
      n_err++;
      $display("FAIL ill_two got e=%b c=%0d want 1 3", sel_err, wr_count);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd0, 4'd4, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h11 || rd_data_b !== 8'h44) begin
      n_err++;
      $display("FAIL ill_nowrite got a=%h b=%h want 11 44",
               rd_data_a, rd_data_b);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    cyc(16'h0300, 8'h99, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    n_cmp++;
    if (sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins got %b want 1", sel_err);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic test_bypass();
    logic [7:0] exp_a;
`ifdef RF_BYPASS_EN
    exp_a = 8'h3C;
`else
    exp_a = 8'h11;
`endif
    cyc(16'h0080, 8'h11, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc(16'h0080, 8'h3C, 1'b1, 1'b1, 4'd7, 4'd4, 1'b0);
    n_cmp++;
    if (rd_data_a !== exp_a || rd_data_b !== 8'h44) begin
      n_err++;
      $display("FAIL same_cycle got a=%h b=%h want %h 44",
               rd_data_a, rd_data_b, exp_a);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h3C || rd_data_b !== 8'h3C) begin
      n_err++;
      $display("FAIL after_wr got a=%h b=%h want 3c 3c",
               rd_data_a, rd_data_b);
    end
    cyc(16'h0180, 8'h77, 1'b1, 1'b1, 4'd7, 4'd8, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h3C || rd_data_b !== 8'h00 || sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL ill_nofwd got a=%h b=%h e=%b want 3c 00 1",
               rd_data_a, rd_data_b, sel_err);
    end
    n_cmp++;
    if (wr_count !== 8'd5) begin
      n_err++;
      $display("FAIL cnt5 got %0d want 5", wr_count);
    end
    cyc(16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      cyc(16'h1 << (i % 16), 8'(i), 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      if (i == 249) begin
        n_cmp++;
        if (wr_count !== 8'd255) begin
          n_err++;
          $display("FAIL sat_reach got %0d want 255", wr_count);
        end
      end
    end
    n_cmp++;
    if (wr_count !== 8'd255) begin
      n_err++;
      $display("FAIL sat_hold got %0d want 255", wr_count);
    end
    // Last write: i=299 -> reg 11 = 0x2B; i=298 -> reg 10 = 0x2A.
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd11, 4'd10, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h2B || rd_data_b !== 8'h2A) begin
      n_err++;
      $display("FAIL sat_data got a=%h b=%h want 2b 2a",
               rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wr_sel = 16'h0004; wr_data = 8'h5A; wr_valid = 1'b1;
    rd_en = 1'b1; rd_addr_a = 4'd11;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_data_a, rd_data_b, rd_valid, sel_err, wr_count} !== 27'd0) begin
      n_err++;
      $display("FAIL async_rst got a=%h b=%h v=%b e=%b c=%0d want 0",
               rd_data_a, rd_data_b, rd_valid, sel_err, wr_count);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(16'h0, 8'h0, 1'b0, 1'b1, 4'd2, 4'd11, 1'b0);
    n_cmp++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || wr_count !== 8'd0) begin
      n_err++;
      $display("FAIL rst_regs got a=%h b=%h c=%0d want 00 00 0",
               rd_data_a, rd_data_b, wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_bypass();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
